// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM state encoding and instruction-width helper
// shared by the multicycle accumulator core and its ALU.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_SHR   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_BRA   = 4'h8;
  localparam logic [3:0] OP_BRAZ  = 4'h9;
  localparam logic [3:0] OP_BRAL  = 4'hA;
  localparam logic [3:0] OP_BRALZ = 4'hB;
  localparam logic [3:0] OP_CALL  = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hD;
  localparam logic [3:0] OP_IN    = 4'hE;
  localparam logic [3:0] OP_OUT   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_STORE,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALTED
  } state_e;

  function automatic int iw_of(input int rf_aw);
    return 4 + 3 * rf_aw;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational datapath ALU; non-ALU opcodes pass operand a
// through so the zero flag doubles as the R[RA]==0 branch test.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] w_o,
  output logic          zero_o
);

  always_comb begin
    w_o = a_i;
    unique case (op_i)
      OP_AND:  w_o = a_i & b_i;
      OP_SHR:  w_o = a_i >> 1;
      OP_ADD:  w_o = a_i + b_i;
      OP_SUB:  w_o = a_i - b_i;
      OP_OR:   w_o = a_i | b_i;
      OP_XOR:  w_o = a_i ^ b_i;
      default: w_o = a_i;
    endcase
  end

  assign zero_o = (w_o == '0);

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multicycle accumulator CPU with loadable IMEM, run/halt
// control and valid/ready IN/OUT ports.
module mc_cpu_core
  import cpu_pkg::*;
#(
  parameter int DW    = 8,
  parameter int RF_AW = 4,
  parameter int IM_AW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [IM_AW-1:0]         prog_addr,
  input  logic [iw_of(RF_AW)-1:0]  prog_data,
  input  logic                     run,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IM_AW-1:0]         pc,
  output logic [iw_of(RF_AW)-1:0]  ir,
  output logic                     busy,
  output logic                     halted
);

  localparam int IW = iw_of(RF_AW);
  localparam int NR = 2 ** RF_AW;
  localparam int NI = 2 ** IM_AW;

  state_e state_q, state_d;

  logic [IM_AW-1:0] pc_q, pc_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [DW-1:0]    w_q, w_d;
  logic [DW-1:0]    out_q, out_d;
  logic             outv_q, outv_d;

  logic [DW-1:0]    rf_q [NR];
  logic [IW-1:0]    imem [NI];

  logic             rf_we;
  logic [DW-1:0]    rf_wd;
  logic [DW-1:0]    alu_w;
  logic             alu_z;

  logic [3:0]       op;
  logic [RF_AW-1:0] ra, rb, rd;
  logic [DW-1:0]    r_a, r_b;
  logic             ctl_idle;

  assign op  = ir_q[IW-1 -: 4];
  assign ra  = ir_q[3*RF_AW-1 -: RF_AW];
  assign rb  = ir_q[2*RF_AW-1 -: RF_AW];
  assign rd  = ir_q[RF_AW-1:0];
  assign r_a = rf_q[ra];
  assign r_b = rf_q[rb];

  assign ctl_idle = (state_q == S_IDLE) || (state_q == S_HALTED);

  cpu_alu #(.DW(DW)) u_alu (
    .op_i   (op),
    .a_i    (r_a),
    .b_i    (r_b),
    .w_o    (alu_w),
    .zero_o (alu_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALTED: if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        unique case (op)
          OP_NOP, OP_BRA, OP_BRAZ,
          OP_BRAL, OP_BRALZ: state_d = S_FETCH;
          OP_HALT: state_d = S_HALTED;
          OP_IN:   state_d = S_WAIT_IN;
          OP_OUT:  state_d = S_WAIT_OUT;
          default: state_d = S_STORE;
        endcase
      end
      S_STORE:    state_d = S_FETCH;
      S_WAIT_IN:  if (in_valid) state_d = S_FETCH;
      S_WAIT_OUT: if (out_ready) state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = !ctl_idle;
    halted   = (state_q == S_HALTED);
    in_ready = (state_q == S_WAIT_IN);
  end

  // Datapath next-state; register reads use pre-write values.
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    w_d    = w_q;
    out_d  = out_q;
    outv_d = outv_q;
    rf_we  = 1'b0;
    rf_wd  = w_q;
    unique case (state_q)
      S_IDLE, S_HALTED: if (run) pc_d = '0;
      S_FETCH:  ir_d = imem[pc_q];
      S_DECODE: pc_d = pc_q + IM_AW'(1);
      S_EXEC: begin
        unique case (op)
          OP_LOAD:  w_d = DW'({ra, rb});
          OP_BRA:   pc_d = IM_AW'(r_b);
          OP_BRAZ:  if (alu_z) pc_d = IM_AW'(r_b);
          OP_BRAL:  pc_d = IM_AW'(rb);
          OP_BRALZ: if (alu_z) pc_d = IM_AW'(rb);
          OP_CALL: begin
            w_d  = DW'(pc_q);
            pc_d = IM_AW'(rb);
          end
          OP_OUT: begin
            out_d  = r_a;
            outv_d = 1'b1;
          end
          OP_AND, OP_SHR, OP_ADD,
          OP_SUB, OP_OR, OP_XOR: w_d = alu_w;
          default: ;
        endcase
      end
      S_STORE: rf_we = 1'b1;
      S_WAIT_IN: begin
        if (in_valid) begin
          rf_we = 1'b1;
          rf_wd = in_data;
        end
      end
      S_WAIT_OUT: if (out_ready) outv_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      w_q    <= '0;
      out_q  <= '0;
      outv_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      w_q    <= w_d;
      out_q  <= out_d;
      outv_q <= outv_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= rf_wd;
    end
  end

  // IMEM is not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && ctl_idle) imem[prog_addr] <= prog_data;
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign out_data  = out_q;
  assign out_valid = outv_q;

endmodule
